// File: rtl/sipo_deser.sv
// rtl/sipo_deser.sv - MSB-first serial-in parallel-out deserializer with valid/ready output and sticky overrun
module sipo_deser #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             sin_en,
    input  logic             clr,
    output logic [WIDTH-1:0] pout,
    output logic             pout_valid,
    input  logic             pout_ready,
    output logic             overrun,
    output logic             busy
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [WIDTH-1:0] r_sr;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_pout;
    logic             r_valid;
    logic             r_overrun;

    logic             w_shift;
    logic             w_last;
    logic             w_load;
    logic             w_take;
    logic [WIDTH-1:0] w_word;

    assign w_shift = sin_en && !clr;
    assign w_last  = w_shift && (r_cnt == CNT_LAST);
    assign w_word  = {r_sr[WIDTH-2:0], sin};
    // A completion may reuse the holding register when the consumer takes the old word this same cycle
    assign w_load  = w_last && (!r_valid || pout_ready);
    assign w_take  = r_valid && pout_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sr      <= '0;
            r_cnt     <= '0;
            r_pout    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (clr) begin
                r_cnt     <= '0;
                r_overrun <= 1'b0;
            end else if (sin_en) begin
                r_sr  <= w_word;
                r_cnt <= w_last ? '0 : r_cnt + CNT_ONE;
                if (w_last && !w_load) begin
                    r_overrun <= 1'b1;
                end
            end

            if (w_load) begin
                r_pout  <= w_word;
                r_valid <= 1'b1;
            end else if (w_take) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign pout       = r_pout;
    assign pout_valid = r_valid;
    assign overrun    = r_overrun;
    assign busy       = (r_cnt != '0);
endmodule

// File: tb/tb_sipo_deser.sv
// tb/tb_sipo_deser.sv - scoreboard bench for sipo_deser against a word-level reference model
module tb_sipo_deser;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         sin = 1'b0;
    logic         sin_en = 1'b0;
    logic         clr = 1'b0;
    logic         pout_ready = 1'b0;
    logic [W-1:0] pout;
    logic         pout_valid;
    logic         overrun;
    logic         busy;

    int errors = 0;
    int checks = 0;

    // Reference model: collected bits of the current word and the state of the output slot
    int m_nbits = 0;
    int m_acc   = 0;
    bit m_valid = 0;
    int m_pout  = 0;
    bit m_ovr   = 0;
    int exp_q[$];

    sipo_deser #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .sin        (sin),
        .sin_en     (sin_en),
        .clr        (clr),
        .pout       (pout),
        .pout_valid (pout_valid),
        .pout_ready (pout_ready),
        .overrun    (overrun),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_nbits = 0;
        m_acc   = 0;
        m_valid = 0;
        m_pout  = 0;
        m_ovr   = 0;
        exp_q.delete();
    endtask

    task automatic model_edge(input bit s, input bit e, input bit c, input bit r);
        bit consume;
        bit loaded;
        consume = m_valid && r;
        loaded  = 0;
        if (c) begin
            m_nbits = 0;
            m_acc   = 0;
            m_ovr   = 0;
        end else if (e) begin
            m_acc = m_acc * 2 + int'(s);
            m_nbits++;
            if (m_nbits == W) begin
                if (!m_valid || r) begin
                    m_pout  = m_acc;
                    m_valid = 1;
                    loaded  = 1;
                    exp_q.push_back(m_acc);
                end else begin
                    m_ovr = 1;
                end
                m_nbits = 0;
                m_acc   = 0;
            end
        end
        if (consume && !loaded) m_valid = 0;
    endtask

    task automatic step(input bit s, input bit e, input bit c, input bit r);
        sin = s; sin_en = e; clr = c; pout_ready = r;
        @(posedge clk);
        if (rst) model_edge(s, e, c, r);
        #1;
    endtask

    task automatic send_word(input int w, input bit r);
        for (int i = W - 1; i >= 0; i--) step(w[i], 1'b1, 1'b0, r);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_pout"}, int'(pout), 0);
        chk({tag, "_valid"}, int'(pout_valid), 0);
        chk({tag, "_ovr"}, int'(overrun), 0);
        chk({tag, "_busy"}, int'(busy), 0);
    endtask

    // Monitor: compares outputs against the model and pops the scoreboard on every handshake
    always @(negedge clk) begin
        if (rst) begin
            chk("mon_valid", int'(pout_valid), int'(m_valid));
            chk("mon_ovr", int'(overrun), int'(m_ovr));
            chk("mon_busy", int'(busy), int'(m_nbits != 0));
            chk("mon_pout", int'(pout), m_pout);
            if (pout_valid && pout_ready) begin
                if (exp_q.size() == 0) begin
                    chk("sb_underflow", 1, 0);
                end else begin
                    chk("sb_word", int'(pout), exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        // Reset held with activity on the inputs
        for (int i = 0; i < 3; i++) begin
            step(i[0], 1'b1, 1'b0, 1'b1);
            chk_zero("reset");
        end
        rst = 1'b1;

        // Basic word 1011
        send_word(4'b1011, 1'b0);
        chk("basic_pout", int'(pout), 4'b1011);
        chk("basic_valid", int'(pout_valid), 1);
        chk("basic_busy", int'(busy), 0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("basic_consumed", int'(pout_valid), 0);
        chk("basic_keep", int'(pout), 4'b1011);

        // Back-to-back streaming with ready held high
        send_word(4'hA, 1'b1);
        chk("b2b_a", int'(pout), 4'hA);
        send_word(4'h5, 1'b1);
        chk("b2b_5", int'(pout), 4'h5);
        send_word(4'hF, 1'b1);
        chk("b2b_f", int'(pout), 4'hF);
        chk("b2b_ovr", int'(overrun), 0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("b2b_drained", int'(pout_valid), 0);

        // Overrun and clear
        send_word(4'h3, 1'b0);
        send_word(4'hC, 1'b0);
        chk("ovr_flag", int'(overrun), 1);
        chk("ovr_pout", int'(pout), 4'h3);
        chk("ovr_valid", int'(pout_valid), 1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("clr_ovr", int'(overrun), 0);
        chk("clr_busy", int'(busy), 0);
        chk("clr_valid", int'(pout_valid), 1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("clr_consumed", int'(pout_valid), 0);

        // Gapped bits, abort, fresh word
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("gap_busy", int'(busy), 1);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        chk("abort_busy", int'(busy), 0);
        send_word(4'b0110, 1'b0);
        chk("abort_pout", int'(pout), 4'b0110);
        step(1'b0, 1'b0, 1'b0, 1'b1);

        // Asynchronous reset between edges, mid-word with a pending word
        send_word(4'h7, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        chk_zero("areset");
        step(1'b1, 1'b1, 1'b0, 1'b1);
        chk_zero("areset_held");
        rst = 1'b1;
        send_word(4'h9, 1'b0);
        chk("post_reset_pout", int'(pout), 4'h9);
        chk("post_reset_valid", int'(pout_valid), 1);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 19) == 0),
                 1'($urandom_range(0, 1)));
        end

        // Drain: every delivered word must have been seen by the monitor
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("sb_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
